// File: rtl/lenet_pkg.sv
// Shared LeNet datapath types: pixel width, signed pixel type and signed max helper.
package lenet_pkg;

  localparam int unsigned DATA_W = 8;

  typedef logic signed [DATA_W-1:0] pixel_t;

  function automatic pixel_t max2(input pixel_t a, input pixel_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-width line buffer for the pooling stage: holds the horizontal maxima of an even row.
// Synchronous write, combinational read on the same address.
module pool_line_buf
  import lenet_pkg::*;
#(
  parameter int unsigned DEPTH = 14,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  pixel_t        i_wdata,
  output pixel_t        o_rdata
);

  pixel_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/max_pool_2x2.sv
// 2x2 stride-2 signed max-pooling over a raster pixel stream.
// Horizontal pairs are reduced in a hold register, vertical pairs through a half-width line buffer.
module max_pool_2x2
  import lenet_pkg::*;
#(
  parameter int unsigned IMG_W = 28,
  parameter int unsigned IMG_H = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              frame_done,
  output logic              sof_err
);

  localparam int unsigned COL_W    = $clog2(IMG_W);
  localparam int unsigned ROW_W    = $clog2(IMG_H);
  localparam int unsigned LB_DEPTH = IMG_W / 2;
  localparam int unsigned LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  if ((IMG_W < 2) || ((IMG_W % 2) != 0)) begin : g_bad_img_w
    $error("max_pool_2x2: IMG_W must be even and >= 2");
  end
  if ((IMG_H < 2) || ((IMG_H % 2) != 0)) begin : g_bad_img_h
    $error("max_pool_2x2: IMG_H must be even and >= 2");
  end

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  pixel_t           r_hold;
  logic             r_out_valid;
  pixel_t           r_out_data;
  logic             r_frame_done;
  logic             r_sof_err;

  logic [COL_W-1:0] w_col;
  logic [ROW_W-1:0] w_row;
  logic             w_restart;
  logic             w_sof_err;
  logic             w_odd_col;
  logic             w_odd_row;
  logic             w_col_last;
  logic             w_row_last;
  logic             w_lb_we;
  logic             w_win_done;
  logic [LB_AW-1:0] w_lb_addr;
  pixel_t           w_hmax;
  pixel_t           w_lb_rdata;
  pixel_t           w_pool;

  // An in_sof beat is always taken as position (0,0), so the effective position is forced there.
  always_comb begin
    w_restart  = in_valid & in_sof;
    w_sof_err  = w_restart & ((r_col != '0) | (r_row != '0));
    w_col      = w_restart ? '0 : r_col;
    w_row      = w_restart ? '0 : r_row;
    w_odd_col  = w_col[0];
    w_odd_row  = w_row[0];
    w_col_last = (w_col == COL_LAST);
    w_row_last = (w_row == ROW_LAST);
    w_lb_addr  = LB_AW'(w_col >> 1);
    w_lb_we    = in_valid & w_odd_col & ~w_odd_row;
    w_win_done = in_valid & w_odd_col & w_odd_row;
    w_hmax     = max2(r_hold, in_data);
    w_pool     = max2(w_lb_rdata, w_hmax);
  end

  pool_line_buf #(
    .DEPTH (LB_DEPTH),
    .AW    (LB_AW)
  ) u_lbuf (
    .clk     (clk),
    .i_we    (w_lb_we),
    .i_addr  (w_lb_addr),
    .i_wdata (w_hmax),
    .o_rdata (w_lb_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col        <= '0;
      r_row        <= '0;
      r_hold       <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_frame_done <= 1'b0;
      r_sof_err    <= 1'b0;
    end else begin
      r_out_valid  <= w_win_done;
      r_frame_done <= w_win_done & w_col_last & w_row_last;
      r_sof_err    <= w_sof_err;
      if (w_win_done) begin
        r_out_data <= w_pool;
      end
      // Position and hold only move on accepted beats; idle cycles leave all state untouched.
      if (in_valid) begin
        if (!w_odd_col) begin
          r_hold <= in_data;
        end
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : w_row + ROW_W'(1);
        end else begin
          r_col <= w_col + COL_W'(1);
          r_row <= w_row;
        end
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign frame_done = r_frame_done;
  assign sof_err    = r_sof_err;

endmodule

// File: tb/tb_max_pool_2x2.sv
// Directed bench for max_pool_2x2: a 4x2 instance for window/sof/reset cases, a 28x28 instance for the ramp.
module tb_max_pool_2x2;
  import lenet_pkg::*;

  typedef struct {
    int data;
    int fd;
    int cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_sof;
  logic [DATA_W-1:0] in_data;
  logic              in_valid_a;
  logic              in_valid_b;
  logic              out_valid_a, frame_done_a, sof_err_a;
  logic              out_valid_b, frame_done_b, sof_err_b;
  logic [DATA_W-1:0] out_data_a, out_data_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_out_a  = 0;
  int   n_out_b  = 0;
  int   n_fd_a   = 0;
  int   n_fd_b   = 0;
  int   n_serr_a = 0;
  int   n_serr_b = 0;
  int   serr_cyc = -1;
  int   sof_cyc  = -2;
  bit   sel_b    = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  max_pool_2x2 #(.IMG_W(4), .IMG_H(2)) u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid_a),
    .in_sof     (in_sof),
    .in_data    (in_data),
    .out_valid  (out_valid_a),
    .out_data   (out_data_a),
    .frame_done (frame_done_a),
    .sof_err    (sof_err_a)
  );

  max_pool_2x2 #(.IMG_W(28), .IMG_H(28)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid_b),
    .in_sof     (in_sof),
    .in_data    (in_data),
    .out_valid  (out_valid_b),
    .out_data   (out_data_b),
    .frame_done (frame_done_b),
    .sof_err    (sof_err_b)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitors: every out_valid must match the next expected entry, including its cycle.
  always @(negedge clk) begin
    if (out_valid_a) begin
      n_out_a++;
      if (q_a.size() == 0) begin
        check_eq("a_extra_valid", 1, 0);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        check_eq("a_data", int'($signed(out_data_a)), e.data);
        check_eq("a_frame_done", int'(frame_done_a), e.fd);
        check_eq("a_latency", cyc, e.cyc);
      end
    end else if (frame_done_a) begin
      check_eq("a_fd_without_valid", 1, 0);
    end
    if (frame_done_a) n_fd_a++;
    if (sof_err_a) begin
      n_serr_a++;
      serr_cyc = cyc;
    end
  end

  always @(negedge clk) begin
    if (out_valid_b) begin
      n_out_b++;
      if (q_b.size() == 0) begin
        check_eq("b_extra_valid", 1, 0);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        check_eq("b_data", int'($signed(out_data_b)), e.data);
        check_eq("b_frame_done", int'(frame_done_b), e.fd);
        check_eq("b_latency", cyc, e.cyc);
      end
    end else if (frame_done_b) begin
      check_eq("b_fd_without_valid", 1, 0);
    end
    if (frame_done_b) n_fd_b++;
    if (sof_err_b) n_serr_b++;
  end

  task automatic drv(input logic sof, input int d);
    @(posedge clk);
    #1;
    in_sof     = sof;
    in_data    = DATA_W'(d);
    in_valid_a = !sel_b;
    in_valid_b = sel_b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_valid_a = 1'b0;
      in_valid_b = 1'b0;
      in_sof     = 1'b0;
    end
  endtask

  // Output appears on the monitor sample one cycle after the current beat.
  task automatic push_a(input int d, input int fd);
    exp_t e;
    e.data = d;
    e.fd   = fd;
    e.cyc  = cyc + 1;
    q_a.push_back(e);
  endtask

  task automatic push_b(input int d, input int fd);
    exp_t e;
    e.data = d;
    e.fd   = fd;
    e.cyc  = cyc + 1;
    q_b.push_back(e);
  endtask

  // One 4x2 frame: px[0..3] row 0, px[4..7] row 1; windows complete on beats 6 and 8.
  task automatic run_frame4(input int px[8], input bit sof0, input int o0, input int o1);
    for (int i = 0; i < 8; i++) begin
      drv((i == 0) ? sof0 : 1'b0, px[i]);
      if (i == 0) sof_cyc = cyc;
      if (i == 5) push_a(o0, 0);
      if (i == 7) push_a(o1, 1);
    end
  endtask

  function automatic int ramp_px(input int r, input int c);
    return (r * 28 + c) & 127;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  initial begin
    int f[8];
    int fd_before;
    int sof_mark;
    rst_n      = 1'b0;
    in_sof     = 1'b0;
    in_data    = '0;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", int'(out_valid_a), 0);
    check_eq("rst_out_data", int'(out_data_a), 0);
    check_eq("rst_frame_done", int'(frame_done_a), 0);
    check_eq("rst_sof_err", int'(sof_err_a), 0);
    check_eq("rst_b_out_valid", int'(out_valid_b), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic pooling with mixed signs, in_valid held high.
    f = '{1, 5, 2, 0, 3, -4, 7, 6};
    run_frame4(f, 1'b1, 5, 7);
    idle(3);

    // All-negative frame must not clamp at zero.
    f = '{-8, -8, -8, -8, -8, -8, -8, -8};
    run_frame4(f, 1'b1, -8, -8);
    idle(2);

    // Two frames back to back; second mixes signs so an unsigned compare would differ.
    fd_before = n_fd_a;
    f = '{10, 20, 30, 40, 50, 60, 70, 80};
    run_frame4(f, 1'b1, 60, 80);
    f = '{9, -9, -20, -7, -3, 4, -128, 127};
    run_frame4(f, 1'b1, 9, 127);
    idle(3);
    check_eq("b2b_frame_done_count", n_fd_a - fd_before, 2);

    // in_sof on beat 3 restarts the frame; the two earlier beats are discarded.
    drv(1'b1, 100);
    drv(1'b0, 100);
    f = '{11, 2, 33, 4, 5, 6, 7, 8};
    run_frame4(f, 1'b1, 11, 33);
    sof_mark = sof_cyc;
    idle(3);
    check_eq("sof_err_count", n_serr_a, 1);
    check_eq("sof_err_cycle", serr_cyc, sof_mark + 1);

    // Reset after 5 beats drops the partial frame; next beat is (0,0) without in_sof.
    for (int i = 0; i < 5; i++) drv((i == 0) ? 1'b1 : 1'b0, 50);
    @(posedge clk);
    #1;
    in_valid_a = 1'b0;
    in_sof     = 1'b0;
    rst_n      = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    f = '{1, 2, 3, 4, 5, 6, 7, 8};
    run_frame4(f, 1'b0, 6, 8);
    idle(3);
    check_eq("a_queue_drained", q_a.size(), 0);
    check_eq("a_out_count", n_out_a, 12);
    check_eq("a_frame_done_count", n_fd_a, 6);
    check_eq("a_sof_err_total", n_serr_a, 1);

    // 28x28 ramp with random idle gaps on the full-size instance.
    sel_b = 1'b1;
    for (int r = 0; r < 28; r++) begin
      for (int c = 0; c < 28; c++) begin
        drv((r == 0 && c == 0) ? 1'b1 : 1'b0, ramp_px(r, c));
        if ((r % 2 == 1) && (c % 2 == 1)) begin
          push_b(imax(imax(ramp_px(r - 1, c - 1), ramp_px(r - 1, c)),
                      imax(ramp_px(r, c - 1), ramp_px(r, c))),
                 (r == 27 && c == 27) ? 1 : 0);
        end
        idle(int'($urandom_range(0, 2)));
      end
    end
    idle(4);
    check_eq("b_queue_drained", q_b.size(), 0);
    check_eq("b_out_count", n_out_b, 196);
    check_eq("b_frame_done_count", n_fd_b, 1);
    check_eq("b_sof_err_total", n_serr_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
